// File: rtl/lza_denorm_if.sv
// lza_denorm_if: handshake bundle for the LZA denormalizer.
// slave = denormalizer side, master = producer/consumer side.
// Signals: in_valid/in_ready/fr/ex (input side),
//          out_valid/out_ready/s/err[/sticky] (result side).
// sticky exists only with LZA_DENORM_STICKY_EN defined.
interface lza_denorm_if;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  fr;
   logic [3:0]  ex;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        err;
`ifdef LZA_DENORM_STICKY_EN
   logic        sticky;

   modport slave (
      input  in_valid, fr, ex, out_ready,
      output in_ready, out_valid, s, err, sticky
   );
   modport master (
      output in_valid, fr, ex, out_ready,
      input  in_ready, out_valid, s, err, sticky
   );
`else
   modport slave (
      input  in_valid, fr, ex, out_ready,
      output in_ready, out_valid, s, err
   );
   modport master (
      output in_valid, fr, ex, out_ready,
      input  in_ready, out_valid, s, err
   );
`endif
endinterface

// File: rtl/lza_denorm.sv
// lza_denorm: sequential denormalizer, one arithmetic right shift per cycle.
// Ports: clk, reset (sync, active-low), bus (lza_denorm_if.slave):
//   in_valid/in_ready/fr[8:0]/ex[3:0] in, out_valid/out_ready/s[15:0]/err out.
// Option: LZA_DENORM_STICKY_EN adds bus.sticky (OR of shifted-out bits).
module lza_denorm (
   input logic          clk,
   input logic          reset,
   lza_denorm_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   logic [8:0]  sr;
   logic [3:0]  cnt;
   logic        err_q;
   logic        rdy_q;
   logic        vld_q;
   logic [3:0]  cnt_ld;
   logic        unnorm;
   logic        acc;

   // Shifts beyond 9 only replicate the sign; clamp the count.
   assign cnt_ld = (bus.ex > 4'd9) ? 4'd9 : bus.ex;
   assign unnorm = (bus.fr[8] == bus.fr[7]) && (bus.fr != 9'd0);
   assign acc    = bus.in_valid && rdy_q;

   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = vld_q;
   assign bus.s         = {{7{sr[8]}}, sr};
   assign bus.err       = err_q;

`ifdef LZA_DENORM_STICKY_EN
   logic st_q;
   assign bus.sticky = st_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q <= 1'b0;
      end else if (state == IDLE) begin
         if (acc) st_q <= 1'b0;
      end else if (state == SHIFT) begin
         st_q <= st_q | sr[0];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         sr    <= 9'd0;
         cnt   <= 4'd0;
         err_q <= 1'b0;
         rdy_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // in_ready is registered, so it rises one cycle after reset.
               if (acc) begin
                  sr    <= bus.fr;
                  cnt   <= cnt_ld;
                  err_q <= unnorm;
                  rdy_q <= 1'b0;
                  if (cnt_ld == 4'd0) begin
                     state <= DONE;
                     vld_q <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end else begin
                  rdy_q <= 1'b1;
               end
            end
            SHIFT: begin
               sr  <= {sr[8], sr[8:1]};
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= DONE;
                  vld_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
                  vld_q <= 1'b0;
                  rdy_q <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               vld_q <= 1'b0;
               rdy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
